// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
// Issues data-memory accesses from the EX/MEM pipeline register to a
// variable-latency memory that uses a req/ack handshake. The pipeline is
// frozen while an access is outstanding. Load data is returned to MEM/WB.
// Misaligned accesses and memory timeouts raise a sticky error.
//
// Flow per access: IDLE (access seen, request latched) -> REQ (request held
// until ack or timeout) -> DONE (pipeline released for one cycle) -> IDLE.
// DONE never accepts a new access because EX/MEM still shows the finished
// instruction during that cycle.

module dmem_access_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16      // legal range 1..255
) (
    input  logic              clk_i,
    input  logic              rst_i,          // asynchronous, active-low

    // EX/MEM stage request
    input  logic              MemRead_i,
    input  logic              MemWrite_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,

    // Data memory handshake
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,

    // Pipeline side
    output logic              stall_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rdata_valid_o,
    output logic              err_o
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last REQ cycle index before the request is abandoned. The counter is
    // zero on the first REQ cycle, so matching TIMEOUT-1 keeps the request
    // up for exactly TIMEOUT cycles.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Word accesses only: the two low address bits must be clear.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

    // ------------------------------------------------------------------
    // Registers and internal wires
    // ------------------------------------------------------------------
    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [7:0]        r_cnt;
    logic              r_we;
    logic              r_is_read;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_err;

    logic              w_access;
    logic              w_aligned;
    logic              w_in_idle;
    logic              w_in_req;
    logic              w_in_done;
    logic              w_accept;      // aligned access launched from IDLE
    logic              w_reject;      // misaligned access seen in IDLE
    logic              w_ack;         // ack qualified by REQ
    logic              w_timeout;     // timeout without ack (ack has priority)

    assign w_access  = MemRead_i | MemWrite_i;
    assign w_aligned = is_word_aligned(addr_i[1:0]);

    assign w_in_idle = (r_state == S_IDLE);
    assign w_in_req  = (r_state == S_REQ);
    assign w_in_done = (r_state == S_DONE);

    assign w_accept  = w_in_idle & w_access &  w_aligned;
    assign w_reject  = w_in_idle & w_access & ~w_aligned;
    assign w_ack     = w_in_req  & mem_ack_i;
    assign w_timeout = w_in_req  & ~mem_ack_i & (r_cnt == CNT_LAST);

    // Next-state selection for the access sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    w_state_nxt = w_aligned ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (w_ack || w_timeout) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // REQ cycle counter: counts while waiting, cleared everywhere else
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (w_in_req) begin
            r_cnt <= r_cnt + 8'd1;
        end else begin
            r_cnt <= '0;
        end
    end

    // Request latch: address, store data and direction frozen for all of REQ
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_we    <= MemWrite_i;      // a store wins if both are raised
        end
    end

    // Access type remembered for the DONE cycle (misaligned ones included)
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_is_read <= 1'b0;
        end else if (w_in_idle && w_access) begin
            r_is_read <= ~MemWrite_i;
        end
    end

    // Load data: captured on a read ack, zeroed on error, otherwise held
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_rdata <= '0;
        end else if (w_reject || w_timeout) begin
            r_rdata <= '0;
        end else if (w_ack && r_is_read) begin
            r_rdata <= mem_rdata_i;
        end
    end

    // Sticky error: only reset clears it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_err <= 1'b0;
        end else if (w_reject || w_timeout) begin
            r_err <= 1'b1;
        end
    end

    // Output decode; the request is a pure state decode so an asynchronous
    // reset drops it at once and any late ack lands outside REQ.
    always_comb begin
        mem_req_o     = w_in_req;
        mem_we_o      = r_we;
        mem_addr_o    = r_addr;
        mem_wdata_o   = r_wdata;
        rdata_o       = r_rdata;
        rdata_valid_o = w_in_done & r_is_read;
        err_o         = r_err;
        stall_o       = w_in_req | (w_in_idle & w_access);
    end

endmodule
